switch_input_port: RTL

- Input stage directly upstream of the CPU's `switches` port. Replaces the raw board switch wiring.
- Synchronises and debounces the 8 slide switches and one "enter" push-button.
- Presents the debounced live value to the CPU, plus a value latched on each button press, with a valid/acknowledge handshake so software polls a stable byte.

---
 rtl/switch_input_port_pkg.sv | 14 +
 rtl/switch_input_port_debounce_cell.sv | 94 +++++++++
 rtl/switch_input_port.sv | 119 +++++++++++
 3 files changed

// File: rtl/switch_input_port_pkg.sv
// Shared types and default parameters for the switch input port.
`timescale 1ns/1ps
package switch_input_port_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_e;

    localparam int WORD_W_DEF      = 8;
    localparam int DEB_CYCLES_DEF  = 16;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/switch_input_port_debounce_cell.sv
// Synchroniser plus debounce FSM for one input group; the whole group commits
// only after DEB_CYCLES consecutive cycles with an unchanged synchronised value.
`timescale 1ns/1ps
module debounce_cell
    import switch_input_port_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] din_raw,
    output logic [WIDTH-1:0] dout
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;

    deb_state_e       state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Metastability synchroniser chain
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_q[0] <= din_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Debounce next-state: any change of the candidate restarts the count
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        case (state_q)
            STABLE: begin
                if (sync_s != stable_q) begin
                    cand_d  = sync_s;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = COUNTING;
                end else begin
                    state_d = STABLE;
                end
            end
            COUNTING: begin
                if (sync_s != cand_q) begin
                    cand_d = sync_s;
                    cnt_d  = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = cand_q;
                    state_d  = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
            end
        endcase
    end

    // Debounce FSM registers
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= STABLE;
            cand_q   <= {WIDTH{1'b0}};
            stable_q <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/switch_input_port.sv
// Debounced switch/button input port with press capture and valid/ack handshake.
// Optional sticky overrun flag enabled by defining SWITCH_PORT_OVERRUN_EN.
`timescale 1ns/1ps
module switch_input_port
    import switch_input_port_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic [WORD_W-1:0] switches_raw,
    input  logic              button_raw,
    input  logic              rd_ack,
    output logic [WORD_W-1:0] switches,
    output logic [WORD_W-1:0] latched,
    output logic              data_valid,
    output logic              press_pulse
`ifdef SWITCH_PORT_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    logic [WORD_W-1:0] sw_stable_s;
    logic              btn_stable_s;

    logic              btn_prev_q, btn_prev_d;
    logic              press_pulse_q, press_pulse_d;
    logic [WORD_W-1:0] latched_q, latched_d;
    logic              data_valid_q, data_valid_d;

    debounce_cell #(
        .WIDTH      (WORD_W),
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sw_deb (
        .clock  (clock),
        .n_reset(n_reset),
        .din_raw(switches_raw),
        .dout   (sw_stable_s)
    );

    debounce_cell #(
        .WIDTH      (1),
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_deb (
        .clock  (clock),
        .n_reset(n_reset),
        .din_raw(button_raw),
        .dout   (btn_stable_s)
    );

    // Edge detect and capture/handshake; a fresh capture beats a same-cycle ack
    always_comb begin
        btn_prev_d    = btn_stable_s;
        press_pulse_d = btn_stable_s & ~btn_prev_q;
        latched_d     = latched_q;
        data_valid_d  = data_valid_q;
        if (press_pulse_q) begin
            latched_d    = sw_stable_s;
            data_valid_d = 1'b1;
        end else if (rd_ack && data_valid_q) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end
    end

    // Press detection and capture registers
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            btn_prev_q    <= 1'b0;
            press_pulse_q <= 1'b0;
            latched_q     <= {WORD_W{1'b0}};
            data_valid_q  <= 1'b0;
        end else begin
            btn_prev_q    <= btn_prev_d;
            press_pulse_q <= press_pulse_d;
            latched_q     <= latched_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign switches    = sw_stable_s;
    assign latched     = latched_q;
    assign data_valid  = data_valid_q;
    assign press_pulse = press_pulse_q;

`ifdef SWITCH_PORT_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky overrun: a press over an unconsumed word, released by ack
    always_comb begin
        overrun_d = overrun_q;
        if (press_pulse_q && data_valid_q && !rd_ack) begin
            overrun_d = 1'b1;
        end else if (rd_ack) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Overrun flag register
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule
